// File: rtl/traffic_pkg.sv
// Shared types and constants for the H2C traffic checker.
// Build option: define TRAFFIC_CHECK_THROTTLE_EN to insert one tx_ready stall
// cycle in every four.
package traffic_pkg;

  // Receive state machine states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [15:0] ETHERTYPE = 16'h00FF;
  localparam int          HDR_BYTES = 14;

  // Bit positions inside the 4-bit error vectors.
  localparam int ERR_HDR  = 0;
  localparam int ERR_DATA = 1;
  localparam int ERR_LEN  = 2;
  localparam int ERR_PAR  = 3;
  localparam int NUM_ERR  = 4;

  // Width of the beat index; plenty of headroom for jumbo-sized frames.
  localparam int BEAT_W = 16;

  // Beats needed to carry a frame of the given byte length.
  function automatic int nbeats(input int frame, input int ben);
    return (frame + ben - 1) / ben;
  endfunction

endpackage

// File: rtl/traffic_beat_check.sv
// Combinational per-beat checker: header match, payload byte pattern and
// per-lane parity for one beat at a given beat index.
module traffic_beat_check
  import traffic_pkg::*;
#(
  parameter int          MAX_ETH_FRAME = 1518,
  parameter int          TX_LEN        = 128,
  parameter int          TX_BEN        = TX_LEN / 8,
  parameter logic [47:0] DST_MAC       = 48'h800000000000,
  parameter logic [47:0] SRC_MAC       = 48'h800000000001
) (
  input  logic [BEAT_W-1:0] beat_idx,
  input  logic [TX_LEN-1:0] tx_data,
  input  logic [TX_BEN-1:0] tx_dpar,
  input  logic              is_header,
  output logic              hdr_mis,
  output logic              data_mis,
  output logic              par_mis
);

  localparam logic [111:0] HDR_EXP = {DST_MAC, SRC_MAC, ETHERTYPE};

  logic [31:0] byte_k;
  logic [7:0]  lane;
  logic [7:0]  exp_byte;

  // The header occupies the low 14 bytes of beat 0 only.
  assign hdr_mis = is_header && (tx_data[111:0] != HDR_EXP);

  // Walk every lane: parity always, pattern only past the header bytes.
  always_comb begin
    // NOTE: every comb output gets a default before any branch, so no latch is inferred.
    data_mis = 1'b0;
    par_mis  = 1'b0;
    byte_k   = '0;
    lane     = '0;
    exp_byte = '0;
    for (int j = 0; j < TX_BEN; j++) begin
      lane   = tx_data[j*8 +: 8];
      byte_k = 32'(beat_idx) * 32'(TX_BEN) + 32'(j);
      if ((^lane) != tx_dpar[j]) par_mis = 1'b1;
      if (byte_k >= 32'(HDR_BYTES)) begin
        // Bytes past the end of the frame are padding and must be zero.
        exp_byte = (byte_k < 32'(MAX_ETH_FRAME)) ? byte_k[7:0] : 8'h00;
        if (lane != exp_byte) data_mis = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_check.sv
// H2C traffic sink/checker: receives beat-streamed frames, checks header,
// payload pattern, parity and length, and keeps good/bad frame counters plus
// sticky error flags for the CSR block.
// Build option: TRAFFIC_CHECK_THROTTLE_EN forces tx_ready low one cycle in four.
module traffic_check
  import traffic_pkg::*;
#(
  parameter int          MAX_ETH_FRAME = 1518,
  parameter int          TX_LEN        = 128,
  parameter int          TX_BEN        = TX_LEN / 8,
  parameter logic [47:0] DST_MAC       = 48'h800000000000,
  parameter logic [47:0] SRC_MAC       = 48'h800000000001
) (
  input  logic              user_clk,
  input  logic              user_reset,
  input  logic [31:0]       control_reg,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [TX_LEN-1:0] tx_data,
  input  logic [TX_BEN-1:0] tx_dpar,
  input  logic              tx_last,
  output logic [31:0]       frame_ok_cnt,
  output logic [31:0]       frame_err_cnt,
  output logic [3:0]        err_flags,
  output logic              error
);

  localparam int                NBEATS    = nbeats(MAX_ETH_FRAME, TX_BEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  state_t               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [NUM_ERR-1:0]   frame_err_q, frame_err_d;
  logic                 done_q, done_d;
  logic [NUM_ERR-1:0]   done_err_q, done_err_d;
  logic                 en_q, en_d;
  logic [31:0]          ok_cnt_q, ok_cnt_d;
  logic [31:0]          err_cnt_q, err_cnt_d;
  logic [NUM_ERR-1:0]   flags_q, flags_d;

  logic                 stall;
  logic                 accept;
  logic                 eof;
  logic [NUM_ERR-1:0]   cur_err;
  logic                 hdr_mis, data_mis, par_mis;
  logic                 unused_ctrl;

  assign unused_ctrl = ^control_reg[31:2];
  assign en_d        = control_reg[1];

`ifdef TRAFFIC_CHECK_THROTTLE_EN
  logic [1:0] thr_q, thr_d;
  assign thr_d = thr_q + 2'd1;
  assign stall = (thr_q == 2'b11);
`else
  assign stall = 1'b0;
`endif

  assign tx_ready = (state_q != IDLE) && !stall;
  assign accept   = tx_valid && tx_ready;

  traffic_beat_check #(
    .MAX_ETH_FRAME (MAX_ETH_FRAME),
    .TX_LEN        (TX_LEN),
    .TX_BEN        (TX_BEN),
    .DST_MAC       (DST_MAC),
    .SRC_MAC       (SRC_MAC)
  ) u_beat_check (
    .beat_idx  (beat_q),
    .tx_data   (tx_data),
    .tx_dpar   (tx_dpar),
    .is_header (state_q == HDR),
    .hdr_mis   (hdr_mis),
    .data_mis  (data_mis),
    .par_mis   (par_mis)
  );

  // Frame FSM: beat tracking, per-frame error accumulation, end-of-frame hand-off.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    frame_err_d = frame_err_q;
    done_d      = 1'b0;
    done_err_d  = '0;
    cur_err     = '0;
    eof         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_q) state_d = HDR;
      end
      HDR: begin
        if (accept) begin
          cur_err[ERR_HDR]  = hdr_mis;
          cur_err[ERR_DATA] = data_mis;
          cur_err[ERR_PAR]  = par_mis;
          beat_d            = BEAT_W'(1);
          if (tx_last) begin
            cur_err[ERR_LEN] = 1'b1;
            eof              = 1'b1;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          cur_err[ERR_DATA] = data_mis;
          cur_err[ERR_PAR]  = par_mis;
          beat_d            = beat_q + BEAT_W'(1);
          if (tx_last) begin
            cur_err[ERR_LEN] = (beat_q != LAST_BEAT);
            eof              = 1'b1;
          end else if (beat_q == LAST_BEAT) begin
            // Overlong frame: flag it and swallow the rest unchecked.
            cur_err[ERR_LEN] = 1'b1;
            state_d          = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && tx_last) eof = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    frame_err_d = frame_err_q | cur_err;
    // The finished frame's verdict moves to a one-cycle pipeline stage so the
    // accumulator is free for a header beat arriving right behind it.
    if (eof) begin
      done_d      = 1'b1;
      done_err_d  = frame_err_q | cur_err;
      frame_err_d = '0;
      beat_d      = '0;
      state_d     = en_q ? HDR : IDLE;
    end
  end

  // Status: saturating counters and sticky flags; clear beats a same-cycle update.
  always_comb begin
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    flags_d   = flags_q;
    if (control_reg[0]) begin
      ok_cnt_d  = '0;
      err_cnt_d = '0;
      flags_d   = '0;
    end else if (done_q) begin
      flags_d = flags_q | done_err_q;
      if (done_err_q == '0) begin
        if (ok_cnt_q != '1) ok_cnt_d = ok_cnt_q + 32'd1;
      end else begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge user_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (user_reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      frame_err_q <= '0;
      done_q      <= 1'b0;
      done_err_q  <= '0;
      en_q        <= 1'b0;
      ok_cnt_q    <= '0;
      err_cnt_q   <= '0;
      flags_q     <= '0;
`ifdef TRAFFIC_CHECK_THROTTLE_EN
      thr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      frame_err_q <= frame_err_d;
      done_q      <= done_d;
      done_err_q  <= done_err_d;
      en_q        <= en_d;
      ok_cnt_q    <= ok_cnt_d;
      err_cnt_q   <= err_cnt_d;
      flags_q     <= flags_d;
`ifdef TRAFFIC_CHECK_THROTTLE_EN
      thr_q       <= thr_d;
`endif
    end
  end

  assign frame_ok_cnt  = ok_cnt_q;
  assign frame_err_cnt = err_cnt_q;
  assign err_flags     = flags_q;
  assign error         = |flags_q;

endmodule
